// File: rtl/sim_mon_pkg.sv
// Shared definitions for the end-of-simulation monitor: state encoding,
// default timing constants and a small width helper.
package sim_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_DRAIN_CYCLES   = 100;
  localparam int DEF_TIMEOUT_CYCLES = 1 << 20;

  // Width of a source index; never below one bit so a single source still works.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_mon_src_sel.sv
// Qualifies each end-of-test source (edge or level) and picks the
// lowest-index active trigger for the current cycle.
module sim_mon_src_sel
  import sim_mon_pkg::*;
#(
  parameter int                 NUM_SRC   = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 2'b10,
  parameter int                 ID_W      = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_done_i,
  output logic               trig_any_o,
  output logic [ID_W-1:0]    win_idx_o
);

  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] prev_d;
  logic [NUM_SRC-1:0] trig;

  // Previous-cycle copy of the done inputs for edge detection; clears to 0 so
  // a level already high right after reset counts as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  // Per-source qualification, then lowest-index priority (scan high to low).
  always_comb begin
    prev_d     = src_done_i;
    trig       = '0;
    trig_any_o = 1'b0;
    win_idx_o  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      trig[i] = EDGE_MASK[i] ? (src_done_i[i] & ~prev_q[i]) : src_done_i[i];
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (trig[i]) begin
        trig_any_o = 1'b1;
        win_idx_o  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sim_end_monitor.sv
// End-of-simulation monitor: waits for the first qualified source (or the
// watchdog), optionally drains for a fixed number of clocks, then freezes
// a verdict and pulses finish_o once.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | waiting for a source trigger or watchdog expiry
// ST_DRAIN | a drain source won; counting out the drain delay
// ST_DONE  | verdict frozen until reset
module sim_end_monitor
  import sim_mon_pkg::*;
#(
  parameter int                 NUM_SRC        = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK      = 2'b10,
  parameter logic [NUM_SRC-1:0] DRAIN_MASK     = 2'b01,
  parameter int                 DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int                 TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int                 CODE_W         = 32,
  parameter int                 ID_W           = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_done_i,
  input  logic [NUM_SRC-1:0] src_pass_i,
  input  logic [CODE_W-1:0]  fail_code_i,
  input  logic               timeout_en_i,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic               finish_o,
  output logic [ID_W-1:0]    src_id_o,
  output logic [CODE_W-1:0]  fail_code_o,
  output logic [31:0]        cycle_cnt_o
);

  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  DRAIN_LIM  = 8'(DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic [7:0]          drain_cnt_q, drain_cnt_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic                finish_q, finish_d;
  logic [ID_W-1:0]     src_id_q, src_id_d;
  logic [CODE_W-1:0]   fail_code_q, fail_code_d;

  logic                trig_any;
  logic [ID_W-1:0]     win_idx;
  logic                wd_fire;

  sim_mon_src_sel #(
    .NUM_SRC   (NUM_SRC),
    .EDGE_MASK (EDGE_MASK),
    .ID_W      (ID_W)
  ) u_src_sel (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_done_i (src_done_i),
    .trig_any_o (trig_any),
    .win_idx_o  (win_idx)
  );

  // State, counters and verdict capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
      win_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      finish_q    <= 1'b0;
      src_id_q    <= '0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      win_q       <= win_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      finish_q    <= finish_d;
      src_id_q    <= src_id_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Next-state and verdict logic; a source verdict always beats the watchdog
  // on the same edge. Expiry uses >= so re-enabling late fires immediately.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    win_d       = win_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    finish_d    = 1'b0;
    src_id_d    = src_id_q;
    fail_code_d = fail_code_q;

    wd_fire = timeout_en_i && (cycle_cnt_q >= TIMEOUT_M1);

    if (state_q != ST_DONE && cycle_cnt_q != 32'hFFFF_FFFF) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    case (state_q)
      ST_RUN: begin
        if (trig_any) begin
          if (DRAIN_MASK[win_idx]) begin
            state_d     = ST_DRAIN;
            win_d       = win_idx;
            drain_cnt_d = '0;
          end else begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            finish_d    = 1'b1;
            pass_d      = src_pass_i[win_idx];
            src_id_d    = win_idx;
            fail_code_d = fail_code_i;
          end
        end else if (wd_fire) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          finish_d    = 1'b1;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          src_id_d    = '0;
          fail_code_d = fail_code_i;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LIM) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          finish_d    = 1'b1;
          pass_d      = src_pass_i[win_q];
          src_id_d    = win_q;
          fail_code_d = fail_code_i;
        end else if (wd_fire) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          finish_d    = 1'b1;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          src_id_d    = '0;
          fail_code_d = fail_code_i;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign finish_o    = finish_q;
  assign src_id_o    = src_id_q;
  assign fail_code_o = fail_code_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Testbench for sim_end_monitor: directed scenarios plus randomized
// stimulus, each checked against a verdict model derived from the rules.
module tb_sim_end_monitor;

  localparam int          MAXC   = 1100;
  localparam int          D      = 100;
  localparam int          TO     = 64;
  localparam logic [1:0]  EDGE_M = 2'b10;
  localparam logic [1:0]  DRN_M  = 2'b01;

  logic        clk;
  logic        rst_n;
  logic [1:0]  src_done_i;
  logic [1:0]  src_pass_i;
  logic [31:0] fail_code_i;
  logic        timeout_en_i;
  logic        done_o, pass_o, timeout_o, finish_o;
  logic [0:0]  src_id_o;
  logic [31:0] fail_code_o;
  logic [31:0] cycle_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]  s_done [MAXC];
  logic [1:0]  s_pass [MAXC];
  logic [31:0] s_code [MAXC];
  logic        s_en   [MAXC];
  int          len;

  int          exp_v;
  logic        exp_to, exp_pass;
  int          exp_id;
  logic [31:0] exp_code;

  sim_end_monitor #(
    .NUM_SRC        (2),
    .EDGE_MASK      (EDGE_M),
    .DRAIN_MASK     (DRN_M),
    .DRAIN_CYCLES   (D),
    .TIMEOUT_CYCLES (TO),
    .CODE_W         (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_done_i   (src_done_i),
    .src_pass_i   (src_pass_i),
    .fail_code_i  (fail_code_i),
    .timeout_en_i (timeout_en_i),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .timeout_o    (timeout_o),
    .finish_o     (finish_o),
    .src_id_o     (src_id_o),
    .fail_code_o  (fail_code_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int l);
    len = l;
    for (int n = 0; n < MAXC; n++) begin
      s_done[n] = 2'b00;
      s_pass[n] = 2'($urandom);
      s_code[n] = $urandom;
      s_en[n]   = 1'b0;
    end
  endtask

  // Verdict model: first qualified trigger edge t, verdict edge t or t+D+1,
  // pre-empted by the first earlier watchdog-eligible edge (not edge t itself).
  task automatic model();
    int t, id, vs, w;
    t = -1; id = 0; w = -1;
    for (int n = 0; n < len && t < 0; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (t < 0) begin
          logic cur, prv, trg;
          cur = s_done[n][i];
          prv = (n > 0) ? s_done[n-1][i] : 1'b0;
          trg = EDGE_M[i] ? (cur & ~prv) : cur;
          if (trg) begin t = n; id = i; end
        end
      end
    end
    vs = (t < 0) ? 32'h7fff_ffff : (DRN_M[id] ? t + D + 1 : t);
    for (int n = 0; n < len && n < vs; n++) begin
      if (w < 0 && s_en[n] && n >= TO - 1 && n != t) w = n;
    end
    exp_to = 1'b0; exp_pass = 1'b0; exp_id = 0; exp_code = '0; exp_v = -1;
    if (w >= 0) begin
      exp_v = w; exp_to = 1'b1; exp_code = s_code[w];
    end else if (vs < len) begin
      exp_v = vs; exp_id = id; exp_pass = s_pass[vs][id]; exp_code = s_code[vs];
    end
  endtask

  task automatic check_cycle(input string nm, input int n);
    logic de, fe;
    int   ce;
    de = (exp_v >= 0) && (exp_v <= n - 1);
    fe = (exp_v >= 0) && (exp_v == n - 1);
    ce = de ? exp_v + 1 : n;
    chk({nm, ".done"},   32'(done_o),   32'(de));
    chk({nm, ".finish"}, 32'(finish_o), 32'(fe));
    chk({nm, ".cnt"},    cycle_cnt_o,   32'(ce));
  endtask

  task automatic run_scen(input string nm);
    model();
    @(negedge clk);
    #2 rst_n = 1'b0;
    src_done_i = '0; src_pass_i = '0; fail_code_i = '0; timeout_en_i = 1'b0;
    #1;
    chk({nm, ".rst_done"},    32'(done_o),    32'd0);
    chk({nm, ".rst_pass"},    32'(pass_o),    32'd0);
    chk({nm, ".rst_timeout"}, 32'(timeout_o), 32'd0);
    chk({nm, ".rst_finish"},  32'(finish_o),  32'd0);
    chk({nm, ".rst_id"},      32'(src_id_o),  32'd0);
    chk({nm, ".rst_code"},    fail_code_o,    32'd0);
    chk({nm, ".rst_cnt"},     cycle_cnt_o,    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < len; n++) begin
      check_cycle(nm, n);
      src_done_i   = s_done[n];
      src_pass_i   = s_pass[n];
      fail_code_i  = s_code[n];
      timeout_en_i = s_en[n];
      @(negedge clk);
    end
    check_cycle(nm, len);
    chk({nm, ".pass"},    32'(pass_o),    32'(exp_pass));
    chk({nm, ".timeout"}, 32'(timeout_o), 32'(exp_to));
    chk({nm, ".id"},      32'(src_id_o),  32'(exp_id));
    chk({nm, ".code"},    fail_code_o,    exp_code);
  endtask

  initial begin
    rst_n = 1'b0;
    src_done_i = '0; src_pass_i = '0; fail_code_i = '0; timeout_en_i = 1'b0;
    repeat (2) @(negedge clk);

    // Drain source level-high at 50 with pass: verdict at edge 151.
    fill(200);
    for (int n = 50; n < len; n++) begin s_done[n][0] = 1'b1; s_pass[n][0] = 1'b1; end
    run_scen("drain_pass");
    chk("drain_pass.edge", 32'(exp_v), 32'd151);

    // Edge source at 30, failing, code 7; held high gives no second pulse.
    fill(100);
    for (int n = 30; n < len; n++) begin s_done[n][1] = 1'b1; s_pass[n][1] = 1'b0; end
    s_code[30] = 32'd7;
    run_scen("edge_fail");

    // src0 at 10 owns the verdict; src1 edge at 20 ignored during drain.
    fill(200);
    for (int n = 10; n < len; n++) s_done[n][0] = 1'b1;
    for (int n = 20; n < len; n++) s_done[n][1] = 1'b1;
    run_scen("drain_owns");

    // Watchdog with no sources: timeout at edge 63.
    fill(100);
    for (int n = 0; n < len; n++) s_en[n] = 1'b1;
    run_scen("wdog");

    // Watchdog disabled: no verdict in 1000 cycles.
    fill(1000);
    run_scen("wdog_off");

    // src1 edge coincides with expiry at edge 63: source wins.
    fill(100);
    for (int n = 0; n < len; n++) s_en[n] = 1'b1;
    for (int n = 63; n < len; n++) s_done[n][1] = 1'b1;
    run_scen("coincide_run");

    // Drain completion at edge 101 coincides with the only enabled expiry.
    fill(130);
    for (int n = 0; n < len; n++) s_done[n][0] = 1'b1;
    s_en[101] = 1'b1;
    run_scen("coincide_drain");

    // Watchdog expiring mid-drain.
    fill(120);
    for (int n = 20; n < len; n++) s_done[n][0] = 1'b1;
    for (int n = 40; n < len; n++) s_en[n] = 1'b1;
    run_scen("wdog_in_drain");

    // Late enable fires immediately once the count is past the limit.
    fill(150);
    for (int n = 80; n < len; n++) s_en[n] = 1'b1;
    run_scen("late_en");

    // Stop mid-drain at 60; the next scenario resets asynchronously from there.
    fill(60);
    for (int n = 10; n < len; n++) s_done[n][0] = 1'b1;
    run_scen("mid_drain");
    fill(40);
    for (int n = 5; n < len; n++) s_done[n][1] = 1'b1;
    run_scen("after_rst");

    // Randomized scenarios.
    for (int r = 0; r < 12; r++) begin
      int p, e_mode, e_from;
      fill(250);
      for (int i = 0; i < 2; i++) begin
        int mode, st;
        mode = $urandom_range(0, 2);
        st   = $urandom_range(0, 200);
        p    = $urandom_range(1, 6);
        for (int n = 0; n < len; n++) begin
          if (mode == 1) s_done[n][i] = ($urandom_range(0, 99) < p);
          if (mode == 2) s_done[n][i] = (n >= st);
        end
      end
      e_mode = $urandom_range(0, 3);
      e_from = $urandom_range(0, 200);
      for (int n = 0; n < len; n++) begin
        case (e_mode)
          0:       s_en[n] = 1'b0;
          1:       s_en[n] = 1'b1;
          2:       s_en[n] = 1'($urandom_range(0, 1));
          default: s_en[n] = (n >= e_from);
        endcase
      end
      run_scen($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
